// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// Shared definitions for the IF/MEM read arbiter: transaction IDs, FSM states
// and AXI size encodings.
package ysyx_22041071_axi_rd_arb_pkg;

  localparam int unsigned ID_IF  = 0;
  localparam int unsigned ID_MEM = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SIZE_1B = 2'b00,
    SIZE_2B = 2'b01,
    SIZE_4B = 2'b10,
    SIZE_8B = 2'b11
  } axi_size_e;

endpackage

// File: rtl/ysyx_22041071_axi_rd_arb_if.sv
// Bundle of the IF/MEM request/response ports and the cpu-side read-master port.
// master = units and read master, slave = the arbiter.
interface ysyx_22041071_axi_rd_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic [LEN_W-1:0]  if_req_len;
  logic [1:0]        if_req_size;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic [1:0]        if_rsp_resp;
  logic              if_rsp_last;

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LEN_W-1:0]  mem_req_len;
  logic [1:0]        mem_req_size;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic [1:0]        mem_rsp_resp;
  logic              mem_rsp_last;

  logic              cpu_ar_valid;
  logic [ID_W-1:0]   cpu_id;
  logic [ADDR_W-1:0] cpu_addr;
  logic [LEN_W-1:0]  cpu_len;
  logic [1:0]        cpu_size;
  logic              cpu_ar_ready;
  logic              cpu_r_valid;
  logic [DATA_W-1:0] cpu_r_data;
  logic [1:0]        cpu_r_resp;

  modport master (
    output if_req_valid, if_req_addr, if_req_len, if_req_size,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp, if_rsp_last,
    output mem_req_valid, mem_req_addr, mem_req_len, mem_req_size,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_resp, mem_rsp_last,
    input  cpu_ar_valid, cpu_id, cpu_addr, cpu_len, cpu_size,
    output cpu_ar_ready, cpu_r_valid, cpu_r_data, cpu_r_resp
  );

  modport slave (
    input  if_req_valid, if_req_addr, if_req_len, if_req_size,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp, if_rsp_last,
    input  mem_req_valid, mem_req_addr, mem_req_len, mem_req_size,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_resp, mem_rsp_last,
    output cpu_ar_valid, cpu_id, cpu_addr, cpu_len, cpu_size,
    input  cpu_ar_ready, cpu_r_valid, cpu_r_data, cpu_r_resp
  );
endinterface

// File: rtl/ysyx_22041071_axi_rd_arb_rr_arb2.sv
// Two-way round-robin picker. Bit 0 is IF, bit 1 is MEM; on contention the
// requester that did not win last time is granted.
module ysyx_22041071_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);
  logic last_mem_reg;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_mem_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_mem_reg <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      last_mem_reg <= grant[1];
    end
  end
endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// IF/MEM read arbiter: grants one request at a time, holds it on the cpu port
// for the whole burst and steers returned beats to the owning unit.
module ysyx_22041071_axi_rd_arb
  import ysyx_22041071_axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) (
  input logic                          clk,
  input logic                          reset_n,
  ysyx_22041071_axi_rd_arb_if.slave    bus
);
  arb_state_e        state_reg, state_next;
  logic              owner_mem_reg;
  logic [ID_W-1:0]   id_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;
  axi_size_e         size_reg;
  logic [LEN_W-1:0]  cnt_reg;

  logic [1:0] req_vec;
  logic [1:0] grant;
  logic       granting;
  logic       beat;
  logic       last_beat;

  // Requests are only offered in IDLE, and masked while reset is held so
  // req_ready reads 0 during reset.
  assign req_vec  = (state_reg == ST_IDLE && reset_n) ?
                    {bus.mem_req_valid, bus.if_req_valid} : 2'b00;
  assign granting = (grant != 2'b00);

  ysyx_22041071_rr_arb2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_vec),
    .update  (granting),
    .grant   (grant)
  );

  assign beat      = (state_reg == ST_WAIT) && bus.cpu_r_valid;
  assign last_beat = beat && (cnt_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (granting)         state_next = ST_ISSUE;
      ST_ISSUE: if (bus.cpu_ar_ready) state_next = ST_WAIT;
      ST_WAIT:  if (last_beat)        state_next = ST_IDLE;
      default:                        state_next = ST_IDLE;
    endcase
  end

  // Request fields are captured only at grant, so they stay stable until the
  // FSM is back in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_mem_reg <= 1'b0;
      id_reg        <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      size_reg      <= SIZE_1B;
      cnt_reg       <= '0;
    end else begin
      if (state_reg == ST_IDLE && granting) begin
        owner_mem_reg <= grant[1];
        id_reg        <= grant[1] ? ID_W'(ID_MEM) : ID_W'(ID_IF);
        addr_reg      <= grant[1] ? bus.mem_req_addr : bus.if_req_addr;
        len_reg       <= grant[1] ? bus.mem_req_len  : bus.if_req_len;
        size_reg      <= axi_size_e'(grant[1] ? bus.mem_req_size : bus.if_req_size);
      end
      if (state_reg == ST_ISSUE && bus.cpu_ar_ready) begin
        cnt_reg <= len_reg;
      end else if (beat && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign bus.if_req_ready  = grant[0];
  assign bus.mem_req_ready = grant[1];

  assign bus.cpu_ar_valid = (state_reg == ST_ISSUE);
  assign bus.cpu_id       = id_reg;
  assign bus.cpu_addr     = addr_reg;
  assign bus.cpu_len      = len_reg;
  assign bus.cpu_size     = size_reg;

  // Data/resp go to both units; only valid and last follow the owner.
  assign bus.if_rsp_valid  = beat && !owner_mem_reg;
  assign bus.mem_rsp_valid = beat &&  owner_mem_reg;
  assign bus.if_rsp_last   = last_beat && !owner_mem_reg;
  assign bus.mem_rsp_last  = last_beat &&  owner_mem_reg;
  assign bus.if_rsp_data   = beat ? bus.cpu_r_data : '0;
  assign bus.mem_rsp_data  = beat ? bus.cpu_r_data : '0;
  assign bus.if_rsp_resp   = beat ? bus.cpu_r_resp : 2'b00;
  assign bus.mem_rsp_resp  = beat ? bus.cpu_r_resp : 2'b00;
endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Directed bench for the IF/MEM read arbiter: grant order, burst counting,
// response steering, issue stalls and asynchronous reset mid-burst.
module tb_ysyx_22041071_axi_rd_arb;
  logic clk;
  logic reset_n;
  int   n_total;
  int   n_pass;

  ysyx_22041071_axi_rd_arb_if bus ();

  ysyx_22041071_axi_rd_arb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered one step after the grant edge (FSM in ISSUE); returns one step
  // after the last-beat edge (FSM back in IDLE).
  task automatic run_burst(input string tag, input logic is_mem, input logic [63:0] addr,
                           input logic [7:0] len, input logic [1:0] size,
                           input logic [63:0] dbase, input int ar_stall,
                           input int gap, input int err_beat);
    int         pulses;
    logic [1:0] rexp;
    logic       ov;
    pulses = 0;
    check({tag, ".ar_valid"}, 64'(bus.cpu_ar_valid), 64'd1);
    check({tag, ".id"},       64'(bus.cpu_id), is_mem ? 64'd1 : 64'd0);
    check({tag, ".addr"},     bus.cpu_addr, addr);
    check({tag, ".len"},      64'(bus.cpu_len), 64'(len));
    check({tag, ".size"},     64'(bus.cpu_size), 64'(size));
    for (int s = 0; s < ar_stall; s++) begin
      bus.cpu_ar_ready = 1'b0;
      #1;
      check({tag, ".stall_ar_valid"}, 64'(bus.cpu_ar_valid), 64'd1);
      check({tag, ".stall_ready"}, 64'({bus.mem_req_ready, bus.if_req_ready}), 64'd0);
      check({tag, ".stall_addr"}, bus.cpu_addr, addr);
      tick();
    end
    bus.cpu_ar_ready = 1'b1;
    tick();
    bus.cpu_ar_ready = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      for (int g = 0; g < gap; g++) begin
        #1;
        check({tag, ".gap_rsp_valid"}, 64'({bus.mem_rsp_valid, bus.if_rsp_valid}), 64'd0);
        tick();
      end
      rexp = (k == err_beat) ? 2'b10 : 2'b00;
      bus.cpu_r_valid = 1'b1;
      bus.cpu_r_data  = dbase + 64'(k);
      bus.cpu_r_resp  = rexp;
      #1;
      ov = is_mem ? bus.mem_rsp_valid : bus.if_rsp_valid;
      pulses += int'(ov);
      $display("%s beat %0d: if_v=%b mem_v=%b data=%h resp=%b last=%b", tag, k,
               bus.if_rsp_valid, bus.mem_rsp_valid, bus.if_rsp_data,
               is_mem ? bus.mem_rsp_resp : bus.if_rsp_resp,
               is_mem ? bus.mem_rsp_last : bus.if_rsp_last);
      check({tag, ".rsp_valid"}, 64'({bus.mem_rsp_valid, bus.if_rsp_valid}),
            is_mem ? 64'd2 : 64'd1);
      check({tag, ".rsp_last"}, 64'(is_mem ? bus.mem_rsp_last : bus.if_rsp_last),
            (k == int'(len)) ? 64'd1 : 64'd0);
      check({tag, ".if_data"},  bus.if_rsp_data, dbase + 64'(k));
      check({tag, ".mem_data"}, bus.mem_rsp_data, dbase + 64'(k));
      check({tag, ".rsp_resp"}, 64'(is_mem ? bus.mem_rsp_resp : bus.if_rsp_resp), 64'(rexp));
      check({tag, ".busy_ready"}, 64'({bus.mem_req_ready, bus.if_req_ready}), 64'd0);
      check({tag, ".addr_hold"}, bus.cpu_addr, addr);
      tick();
      bus.cpu_r_valid = 1'b0;
    end
    check({tag, ".done_ar_valid"}, 64'(bus.cpu_ar_valid), 64'd0);
    check({tag, ".pulses"}, 64'(pulses), 64'(len) + 64'd1);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    bus.cpu_ar_ready = 1'b0;
    bus.cpu_r_valid  = 1'b0;
    bus.cpu_r_data   = '0;
    bus.cpu_r_resp   = 2'b00;
    // Both units request from reset.
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 64'h0000_0000_8000_1000;
    bus.if_req_len    = 8'd2;
    bus.if_req_size   = 2'b11;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_addr  = 64'h0000_0000_A000_0040;
    bus.mem_req_len   = 8'd1;
    bus.mem_req_size  = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    check("rst.if_ready",  64'(bus.if_req_ready), 64'd0);
    check("rst.mem_ready", 64'(bus.mem_req_ready), 64'd0);
    check("rst.ar_valid",  64'(bus.cpu_ar_valid), 64'd0);
    check("rst.id",        64'(bus.cpu_id), 64'd0);
    check("rst.addr",      bus.cpu_addr, 64'd0);
    check("rst.rsp_valid", 64'({bus.mem_rsp_valid, bus.if_rsp_valid}), 64'd0);

    // Contention from reset: MEM wins first.
    reset_n = 1'b1;
    #1;
    $display("grant0: if_ready=%b mem_ready=%b", bus.if_req_ready, bus.mem_req_ready);
    check("g0.ready", 64'({bus.mem_req_ready, bus.if_req_ready}), 64'd2);
    tick();
    bus.mem_req_valid = 1'b0;
    run_burst("mem1", 1'b1, 64'h0000_0000_A000_0040, 8'd1, 2'b10,
              64'hA5A5_0000_0000_0000, 5, 0, -1);

    // IF has been waiting; MEM re-requests at the same time -> IF wins now.
    bus.mem_req_valid = 1'b1;
    bus.mem_req_addr  = 64'h0000_0000_A000_0080;
    bus.mem_req_len   = 8'd0;
    bus.mem_req_size  = 2'b01;
    #1;
    check("g1.ready", 64'({bus.mem_req_ready, bus.if_req_ready}), 64'd1);
    tick();
    bus.if_req_valid = 1'b0;
    run_burst("if1", 1'b0, 64'h0000_0000_8000_1000, 8'd2, 2'b11,
              64'h0102_0304_0000_0000, 0, 1, -1);

    // IF requests again while MEM still waits -> MEM wins (alternation).
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h0000_0000_8000_0000;
    bus.if_req_len   = 8'd0;
    bus.if_req_size  = 2'b11;
    #1;
    check("g2.ready", 64'({bus.mem_req_ready, bus.if_req_ready}), 64'd2);
    tick();
    bus.mem_req_valid = 1'b0;
    run_burst("mem2", 1'b1, 64'h0000_0000_A000_0080, 8'd0, 2'b01,
              64'h0000_0000_0000_BEEF, 0, 0, -1);

    // IF single-beat fetch at 0x8000_0000.
    #1;
    check("g3.ready", 64'({bus.mem_req_ready, bus.if_req_ready}), 64'd1);
    tick();
    bus.if_req_valid = 1'b0;
    run_burst("if_single", 1'b0, 64'h0000_0000_8000_0000, 8'd0, 2'b11,
              64'h1122_3344_5566_7788, 0, 0, -1);

    // Stray beat while idle is ignored.
    bus.cpu_r_valid = 1'b1;
    bus.cpu_r_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    check("idle.rsp_valid", 64'({bus.mem_rsp_valid, bus.if_rsp_valid}), 64'd0);
    tick();
    bus.cpu_r_valid = 1'b0;

    // MEM burst of 4 with 2-cycle beat gaps and a SLVERR on beat 1.
    bus.mem_req_valid = 1'b1;
    bus.mem_req_addr  = 64'h0000_0000_A000_0100;
    bus.mem_req_len   = 8'd3;
    bus.mem_req_size  = 2'b11;
    #1;
    check("g4.ready", 64'({bus.mem_req_ready, bus.if_req_ready}), 64'd2);
    tick();
    bus.mem_req_valid = 1'b0;
    run_burst("mem_gap", 1'b1, 64'h0000_0000_A000_0100, 8'd3, 2'b11,
              64'h5555_0000_0000_0010, 0, 2, 1);

    // Asynchronous reset during beat 2 of a 4-beat MEM burst.
    bus.mem_req_valid = 1'b1;
    bus.mem_req_addr  = 64'h0000_0000_A000_0200;
    bus.mem_req_len   = 8'd3;
    #1;
    check("g5.ready", 64'(bus.mem_req_ready), 64'd1);
    tick();
    bus.mem_req_valid = 1'b0;
    bus.cpu_ar_ready  = 1'b1;
    tick();
    bus.cpu_ar_ready  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.cpu_r_valid = 1'b1;
      bus.cpu_r_data  = 64'h7700 + 64'(k);
      tick();
    end
    bus.cpu_r_data = 64'h7702;
    #1;
    check("rst2.pre_valid", 64'(bus.mem_rsp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    $display("async reset: mem_v=%b data=%h addr=%h", bus.mem_rsp_valid, bus.mem_rsp_data, bus.cpu_addr);
    check("rst2.mem_valid", 64'(bus.mem_rsp_valid), 64'd0);
    check("rst2.mem_data",  bus.mem_rsp_data, 64'd0);
    check("rst2.addr",      bus.cpu_addr, 64'd0);
    check("rst2.len",       64'(bus.cpu_len), 64'd0);
    bus.cpu_r_valid = 1'b0;
    tick();
    reset_n = 1'b1;

    // Fresh IF burst after reset counts from its own length.
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h0000_0000_8000_2000;
    bus.if_req_len   = 8'd1;
    bus.if_req_size  = 2'b10;
    #1;
    check("g6.ready", 64'({bus.mem_req_ready, bus.if_req_ready}), 64'd1);
    tick();
    bus.if_req_valid = 1'b0;
    run_burst("if_after_rst", 1'b0, 64'h0000_0000_8000_2000, 8'd1, 2'b10,
              64'h0BAD_F00D_0000_0000, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
# ysyx_22041071_axi_rd_arb

Two-port read arbiter sitting directly upstream of the AXI read master, on its cpu-side request port. It accepts read requests from the instruction-fetch (IF) and load/store (MEM) units, grants one at a time, and launches the granted request with a unique ID. It holds that request stable for the whole transaction, counts returned beats, and routes each beat back to the owning unit with a last flag.

## Interface
- ADDR_W, 64, request address width
- DATA_W, 64, read data width
- LEN_W, 8, AXI burst length field width (beats = len+1)
- ID_W, 4, transaction ID width; IF uses ID 0, MEM uses ID 1

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req_valid / mem_req_valid  in  1  request pending; held until matching ready
- if_req_addr / mem_req_addr  in  ADDR_W  byte address
- if_req_len / mem_req_len  in  LEN_W  burst length minus one
- if_req_size / mem_req_size  in  2  00=1B, 01=2B, 10=4B, 11=8B
- if_req_ready / mem_req_ready  out  1  request accepted this cycle
- if_rsp_valid / mem_rsp_valid  out  1  one returned beat, single-cycle pulse
- if_rsp_data / mem_rsp_data  out  DATA_W  beat data
- if_rsp_resp / mem_rsp_resp  out  2  AXI RRESP of beat
- if_rsp_last / mem_rsp_last  out  1  final beat of the burst
- cpu_ar_valid  out  1  request to read master
- cpu_id  out  ID_W  granted ID
- cpu_addr  out  ADDR_W  latched address, stable until transaction ends
- cpu_len  out  LEN_W  latched length
- cpu_size  out  2  latched size
- cpu_ar_ready  in  1  read master idle/accepting
- cpu_r_valid  in  1  beat returned, each high cycle is one beat
- cpu_r_data  in  DATA_W  beat data (already lane-masked)
- cpu_r_resp  in  2  beat response

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req_valid, choose winner, latch addr/len/size/ID/owner, pulse that unit's req_ready for one cycle, go ISSUE. Both pending: round-robin using a last-grant bit (reset value = IF, so MEM wins the first contention). Single pending: it wins.
- ISSUE: cpu_ar_valid=1; on cpu_ar_valid & cpu_ar_ready, load beat counter with latched len, go WAIT.
- WAIT: each cpu_r_valid cycle forwards data/resp to the owner's rsp port with rsp_valid=1. Counter==0 on a beat sets rsp_last=1 and returns to IDLE; otherwise the counter decrements.
- Non-owner rsp_valid stays 0. rsp_data/resp are driven to both ports; only valid differs.
- New requests are not accepted outside IDLE. req_ready is never asserted in ISSUE/WAIT.
- A non-OKAY resp is forwarded unchanged and does not abort the count.
- Async reset at any point: state IDLE, counter 0, last-grant=IF, all outputs 0. No in-flight transaction is resumed.

## Timing
- Reset values: every output 0; cpu_id=0.
- req_valid in IDLE -> req_ready same cycle (combinational from state and arbitration) -> cpu_ar_valid next cycle.
- cpu_addr/len/size/id are registered and unchanged from ISSUE entry until the cycle after the last beat.
- rsp_valid/data/resp/last are combinational pass-throughs of the cpu_r_* beat in WAIT, giving zero added latency.
- cpu_r_valid outside WAIT is ignored.
- Last beat and a new req_valid in the same cycle: the new request is granted in the following cycle (IDLE).
- len=0: the single beat carries last=1.
- len=255: 256 beats, counter width LEN_W, no wrap.

## Structure
- Shared package: ID constants (IF=0, MEM=1), state encoding, size encoding.
- Sub-module ysyx_22041071_rr_arb2: 2-way round-robin picker (req[1:0], update -> grant[1:0], last-grant register). Everything else stays in the top level.

## Test plan
- IF alone, addr 0x8000_0000, len 0, size 11 -> if_req_ready 1 cycle; cpu_ar_valid next cycle with id 0; one beat 0x1122334455667788 -> if_rsp_valid=1, last=1; mem_rsp_valid stays 0.
- IF and MEM both valid from reset -> MEM granted first (id 1); after its last beat, IF granted; repeat with both held -> alternating grants.
- MEM burst len 3 with beats stalled 2 cycles between them -> exactly 4 mem_rsp_valid pulses, last only on the 4th; cpu_addr unchanged throughout.
- cpu_ar_ready held low 5 cycles in ISSUE -> cpu_ar_valid stays 1 with stable fields; no req_ready pulses.
- Beat with resp 2'b10 mid-burst -> forwarded with resp=10; count continues to last.
- reset_n low during WAIT beat 2 of 4 -> outputs 0 immediately (async); after release, a new IF request is issued normally with a counter starting at its own len.
